pipe_hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage pipeline. It sequences the decode/execute pipeline register.
- Generates per-operand forwarding selects (the adepen/bdepen/sdepen codes consumed in E), load-use stalls, branch/jump flushes, and multicycle-MDU interlock.
- Keeps its own shadow scoreboard of the E and M stage destinations, updated consistently with the stalls and bubbles it issues.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Depen codes match the E-stage operand mux select encoding.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] DEP_RF   = 2'b00;
    localparam logic [1:0] DEP_EALU = 2'b01;
    localparam logic [1:0] DEP_MALU = 2'b10;
    localparam logic [1:0] DEP_MMEM = 2'b11;

    // Destination-side view of one pipeline stage, as tracked by the shadow scoreboard.
    typedef struct packed {
        logic [REG_W-1:0] rn;
        logic             wreg;
        logic             m2reg;
    } shadow_t;

    // True when a stage will write a non-zero register equal to src.
    function automatic logic writes_reg(input shadow_t sh, input logic [REG_W-1:0] src);
        return sh.wreg && (sh.rn == src) && (src != '0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select: picks the youngest in-flight producer of src.
// A load in E cannot forward; that case is covered by the load-use stall.
module pipe_hazard_ctrl_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  shadow_t          e_sh,
    input  shadow_t          m_sh,
    output logic [1:0]       dep
);

    always_comb begin
        dep = DEP_RF;
        if (use_src) begin
            if (writes_reg(e_sh, src) && !e_sh.m2reg) begin
                dep = DEP_EALU;
            end else if (writes_reg(m_sh, src)) begin
                dep = m_sh.m2reg ? DEP_MMEM : DEP_MALU;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: forwarding selects,
// load-use and MDU stalls, redirect flushes, and a shadow E/M destination scoreboard.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic             d_use_rs,
    input  logic             d_use_rt,
    input  logic             d_store,
    input  logic [REG_W-1:0] d_rn,
    input  logic             d_wreg,
    input  logic             d_m2reg,
    input  logic             d_mdu_op,
    input  logic             e_redirect,
    output logic             wpcir,
    output logic             fd_flush,
    output logic             de_bubble,
    output logic [1:0]       adepen,
    output logic [1:0]       bdepen,
    output logic [1:0]       sdepen,
    output logic             mdu_busy
);

    shadow_t          d_sh;
    shadow_t          e_sh;
    shadow_t          m_sh;
    logic [CNT_W-1:0] cnt;
    logic             cnt_nz;
    logic             load_use;
    logic             mdu_stall;
    logic [1:0]       a_sel;
    logic [1:0]       b_sel;
    logic [1:0]       s_sel;

    assign d_sh = '{rn: d_rn, wreg: d_wreg, m2reg: d_m2reg};

    pipe_hazard_ctrl_fwd_sel u_fwd_a (
        .src     (d_rs),
        .use_src (d_use_rs),
        .e_sh    (e_sh),
        .m_sh    (m_sh),
        .dep     (a_sel)
    );

    pipe_hazard_ctrl_fwd_sel u_fwd_b (
        .src     (d_rt),
        .use_src (d_use_rt),
        .e_sh    (e_sh),
        .m_sh    (m_sh),
        .dep     (b_sel)
    );

    pipe_hazard_ctrl_fwd_sel u_fwd_s (
        .src     (d_rt),
        .use_src (d_store),
        .e_sh    (e_sh),
        .m_sh    (m_sh),
        .dep     (s_sel)
    );

    // While reset is sampled the pipeline must look idle: no forwarding, no busy.
    assign adepen   = clrn ? DEP_RF : a_sel;
    assign bdepen   = clrn ? DEP_RF : b_sel;
    assign sdepen   = clrn ? DEP_RF : s_sel;
    assign cnt_nz   = (cnt != '0);
    assign mdu_busy = cnt_nz && !clrn;

    always_comb begin
        load_use  = e_sh.wreg && e_sh.m2reg && (e_sh.rn != '0) &&
                    ((d_use_rs && (e_sh.rn == d_rs)) ||
                     ((d_use_rt || d_store) && (e_sh.rn == d_rt)));
        mdu_stall = cnt_nz && d_mdu_op;
    end

    // Priority: reset > redirect > load-use > MDU interlock > normal flow.
    always_comb begin
        wpcir     = 1'b1;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
        if (!clrn) begin
            if (e_redirect) begin
                fd_flush  = 1'b1;
                de_bubble = 1'b1;
            end else if (load_use || mdu_stall) begin
                wpcir     = 1'b0;
                de_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            e_sh <= '0;
            m_sh <= '0;
            cnt  <= '0;
        end else begin
            m_sh <= e_sh;
            e_sh <= de_bubble ? shadow_t'('0) : d_sh;
            // Only an MDU op that actually enters E (re)starts the busy window.
            if (d_mdu_op && !de_bubble) begin
                cnt <= CNT_W'(MDU_LAT);
            end else if (cnt_nz) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle expected outputs go through a queue
// and are compared against the DUT at the falling edge.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       clrn;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic       d_use_rs;
    logic       d_use_rt;
    logic       d_store;
    logic [4:0] d_rn;
    logic       d_wreg;
    logic       d_m2reg;
    logic       d_mdu_op;
    logic       e_redirect;
    logic       wpcir;
    logic       fd_flush;
    logic       de_bubble;
    logic [1:0] adepen;
    logic [1:0] bdepen;
    logic [1:0] sdepen;
    logic       mdu_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // {wpcir, fd_flush, de_bubble, adepen, bdepen, sdepen, mdu_busy}
    logic [9:0] exp_q[$];

    pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_use_rs   (d_use_rs),
        .d_use_rt   (d_use_rt),
        .d_store    (d_store),
        .d_rn       (d_rn),
        .d_wreg     (d_wreg),
        .d_m2reg    (d_m2reg),
        .d_mdu_op   (d_mdu_op),
        .e_redirect (e_redirect),
        .wpcir      (wpcir),
        .fd_flush   (fd_flush),
        .de_bubble  (de_bubble),
        .adepen     (adepen),
        .bdepen     (bdepen),
        .sdepen     (sdepen),
        .mdu_busy   (mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] mk(input logic w, input logic f, input logic b,
                                      input logic [1:0] a, input logic [1:0] bd,
                                      input logic [1:0] s, input logic busy);
        return {w, f, b, a, bd, s, busy};
    endfunction

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic st, input logic [4:0] rn,
                         input logic wr, input logic ld, input logic mdu, input logic redir);
        d_rs = rs; d_rt = rt; d_use_rs = urs; d_use_rt = urt; d_store = st;
        d_rn = rn; d_wreg = wr; d_m2reg = ld; d_mdu_op = mdu; e_redirect = redir;
    endtask

    // One pipeline cycle: queue the expectation, check mid-cycle, advance past the edge.
    task automatic cyc(input string tag, input logic [9:0] e);
        logic [9:0] obs;
        logic [9:0] want;
        exp_q.push_back(e);
        @(negedge clk);
        obs = {wpcir, fd_flush, de_bubble, adepen, bdepen, sdepen, mdu_busy};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
        end else begin
            want = exp_q.pop_front();
            assert (obs === want) else begin
                n_fail++;
                $error("FAIL %s: observed w/f/b/a/b/s/busy=%b expected %b", tag, obs, want);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn = 1'b1;
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        cyc("reset_idle", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        clrn = 1'b0;

        // ALU back-to-back forwarding from E then M
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd3, 1, 0, 0, 0);
        cyc("alu_producer", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        set_d(5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0, 0);
        cyc("fwd_e_alu", mk(1, 0, 0, 2'b01, 2'b00, 2'b00, 0));
        set_d(5'd3, 5'd3, 1, 1, 0, 5'd0, 0, 0, 0, 0);
        cyc("fwd_m_alu", mk(1, 0, 0, 2'b10, 2'b10, 2'b00, 0));

        // Load-use: one stall then memory-data forward
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd5, 1, 1, 0, 0);
        cyc("load_r5", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        set_d(5'd0, 5'd5, 0, 1, 0, 5'd6, 1, 0, 0, 0);
        cyc("load_use_stall", mk(0, 0, 1, 2'b00, 2'b00, 2'b00, 0));
        cyc("load_use_release", mk(1, 0, 0, 2'b00, 2'b11, 2'b00, 0));

        // Store two behind a load; r0 sources never forward
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd7, 1, 1, 0, 0);
        cyc("load_r7", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        cyc("nop_gap", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        set_d(5'd0, 5'd7, 0, 0, 1, 5'd0, 1, 0, 0, 0);
        cyc("store_fwd_mmem", mk(1, 0, 0, 2'b00, 2'b00, 2'b11, 0));
        set_d(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, 0);
        cyc("r0_vs_e_shadow", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        set_d(5'd0, 5'd0, 1, 0, 0, 5'd0, 1, 1, 0, 0);
        cyc("r0_vs_m_shadow", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        set_d(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, 0);
        cyc("r0_load_no_stall", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));

        // E has priority over M for the same register
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd4, 1, 0, 0, 0);
        cyc("r4_first", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        cyc("r4_second", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        set_d(5'd4, 5'd4, 1, 1, 0, 5'd0, 0, 0, 0, 0);
        cyc("e_over_m", mk(1, 0, 0, 2'b01, 2'b01, 2'b00, 0));

        // MDU interlock: mult then mfhi stalls four cycles
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0);
        cyc("mult_issue", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd8, 1, 0, 1, 0);
        cyc("mfhi_stall_1", mk(0, 0, 1, 2'b00, 2'b00, 2'b00, 1));
        cyc("mfhi_stall_2", mk(0, 0, 1, 2'b00, 2'b00, 2'b00, 1));
        cyc("mfhi_stall_3", mk(0, 0, 1, 2'b00, 2'b00, 2'b00, 1));
        cyc("mfhi_stall_4", mk(0, 0, 1, 2'b00, 2'b00, 2'b00, 1));
        cyc("mfhi_release", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        set_d(5'd8, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0, 0);
        cyc("non_mdu_no_stall", mk(1, 0, 0, 2'b01, 2'b00, 2'b00, 1));
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        cyc("busy_counting", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 1));

        // Redirect overrides a load-use and an MDU hazard together
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd9, 1, 1, 0, 0);
        cyc("load_r9", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 1));
        set_d(5'd9, 5'd0, 1, 0, 0, 5'd0, 0, 0, 1, 1);
        cyc("redirect_wins", mk(1, 1, 1, 2'b00, 2'b00, 2'b00, 1));
        set_d(5'd9, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0, 0);
        cyc("after_redirect", mk(1, 0, 0, 2'b11, 2'b00, 2'b00, 0));

        // Reset mid-count with a load in E
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0);
        cyc("mult_again", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd10, 1, 1, 0, 0);
        cyc("load_r10", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 1));
        clrn = 1'b1;
        set_d(5'd10, 5'd10, 1, 1, 0, 5'd0, 0, 0, 1, 0);
        cyc("reset_mid_stall", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        clrn = 1'b0;
        cyc("post_reset_clear", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        set_d(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        cyc("post_reset_mdu", mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
